// File: rtl/load_mem_ctrl_pkg.sv
// Shared CPU constants, load-unit FSM states and the captured load payload.
package load_mem_ctrl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  localparam logic [1:0] BYTE        = 2'b00;
  localparam logic [1:0] HALF_WORD   = 2'b01;
  localparam logic [1:0] WORD        = 2'b10;
  localparam logic [1:0] DOUBLE_WORD = 2'b11;

  localparam logic [1:0] RF_SRC_MEM  = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4,
    ERR   = 3'd5
  } ld_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [1:0]      byte_en;
    logic            zero_extnd;
    logic [RD_W-1:0] rd;
  } ld_req_t;

endpackage

// File: rtl/ld_align_chk.sv
// Natural-alignment check of a load: offset within the 64-bit row vs access size.
module ld_align_chk
  import load_mem_ctrl_pkg::*;
(
  input  logic [2:0] i_addr_lo,
  input  logic [1:0] i_byte_en,
  output logic       o_misaligned_c
);

  always_comb begin
    o_misaligned_c = 1'b0;
    unique case (i_byte_en)
      BYTE:        o_misaligned_c = 1'b0;
      HALF_WORD:   o_misaligned_c = i_addr_lo[0];
      WORD:        o_misaligned_c = |i_addr_lo[1:0];
      DOUBLE_WORD: o_misaligned_c = |i_addr_lo;
      default:     o_misaligned_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_mem_ctrl.sv
// RV64 load sequencer: one outstanding aligned row read, raw row plus lane
// controls to writeback, misalignment trap and flush/drain handling.
module load_mem_ctrl
  import load_mem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [XLEN-1:0] ld_addr_i,
  input  logic [1:0]      ld_byte_en_i,
  input  logic            ld_zero_extnd_i,
  input  logic [RD_W-1:0] ld_rd_i,
  input  logic            flush_i,
  output logic            dmem_req_o,
  output logic [XLEN-1:0] dmem_addr_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [XLEN-1:0] data_mem_rd_o,
  output logic [1:0]      data_byte_en_o,
  output logic            data_zero_extnd_o,
  output logic [2:0]      data_mem_row_idx_o,
  output logic            stall_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  ld_state_t       r_state;
  ld_state_t       w_next;
  ld_req_t         r_req;
  logic [XLEN-1:0] r_rdata;
  logic            w_misaligned;
  logic            w_ready;
  logic            w_accept;
  logic            w_capture_data;

  ld_align_chk u_align_chk (
    .i_addr_lo      (ld_addr_i[2:0]),
    .i_byte_en      (ld_byte_en_i),
    .o_misaligned_c (w_misaligned)
  );

  assign w_ready        = (r_state == IDLE) && !flush_i;
  assign w_accept       = ld_valid_i && w_ready;
  assign w_capture_data = (r_state == WAIT) && dmem_rvalid_i && !flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next          = r_state;
    ld_ready_o      = w_ready;
    dmem_req_o      = 1'b0;
    wb_valid_o      = 1'b0;
    stall_o         = 1'b0;
    misalign_o      = 1'b0;
    misalign_addr_o = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next  = w_misaligned ? ERR : REQ;
          stall_o = !w_misaligned;
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i)   w_next = flush_i ? DRAIN : WAIT;
        else if (flush_i) w_next = IDLE;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) w_next = flush_i ? IDLE : RESP;
        else if (flush_i)  w_next = DRAIN;
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) w_next = IDLE;
      end
      RESP: begin
        wb_valid_o = !flush_i;
        w_next     = IDLE;
      end
      ERR: begin
        misalign_o      = 1'b1;
        misalign_addr_o = r_req.addr;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Payload capture; held until the next accept / data return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req.addr       <= ld_addr_i;
        r_req.byte_en    <= ld_byte_en_i;
        r_req.zero_extnd <= ld_zero_extnd_i;
        r_req.rd         <= ld_rd_i;
      end
      if (w_capture_data) r_rdata <= dmem_rdata_i;
    end
  end

  assign dmem_addr_o        = {r_req.addr[XLEN-1:3], 3'b000};
  assign wb_rd_o            = r_req.rd;
  assign data_mem_rd_o      = r_rdata;
  assign data_byte_en_o     = r_req.byte_en;
  assign data_zero_extnd_o  = r_req.zero_extnd;
  assign data_mem_row_idx_o = r_req.addr[2:0];

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Directed bench for load_mem_ctrl with hand-computed expected values.
module tb_load_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [63:0] ld_addr_i;
  logic [1:0]  ld_byte_en_i;
  logic        ld_zero_extnd_i;
  logic [4:0]  ld_rd_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic [63:0] dmem_addr_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] data_mem_rd_o;
  logic [1:0]  data_byte_en_o;
  logic        data_zero_extnd_o;
  logic [2:0]  data_mem_row_idx_o;
  logic        stall_o;
  logic        misalign_o;
  logic [63:0] misalign_addr_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  load_mem_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .ld_valid_i         (ld_valid_i),
    .ld_ready_o         (ld_ready_o),
    .ld_addr_i          (ld_addr_i),
    .ld_byte_en_i       (ld_byte_en_i),
    .ld_zero_extnd_i    (ld_zero_extnd_i),
    .ld_rd_i            (ld_rd_i),
    .flush_i            (flush_i),
    .dmem_req_o         (dmem_req_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_gnt_i         (dmem_gnt_i),
    .dmem_rvalid_i      (dmem_rvalid_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .wb_valid_o         (wb_valid_o),
    .wb_rd_o            (wb_rd_o),
    .data_mem_rd_o      (data_mem_rd_o),
    .data_byte_en_o     (data_byte_en_o),
    .data_zero_extnd_o  (data_zero_extnd_o),
    .data_mem_row_idx_o (data_mem_row_idx_o),
    .stall_o            (stall_o),
    .misalign_o         (misalign_o),
    .misalign_addr_o    (misalign_addr_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writeback lane select/extension applied to the payload outputs
  function automatic logic [63:0] wb_lane(input logic [63:0] row, input logic [2:0] idx,
                                          input logic [1:0] be, input logic z);
    logic [63:0] v;
    v = row >> (8 * idx);
    case (be)
      2'b00:   wb_lane = z ? {56'd0, v[7:0]}  : {{56{v[7]}}, v[7:0]};
      2'b01:   wb_lane = z ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      2'b10:   wb_lane = z ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: wb_lane = v;
    endcase
  endfunction

  task automatic do_load(input logic [63:0] addr, input logic [1:0] be, input logic z,
                         input logic [4:0] rd, input int gnt_dly, input logic [63:0] rdata,
                         input logic [63:0] exp_lane);
    logic [63:0] row;
    row = addr & ~64'h7;
    ld_valid_i = 1'b1; ld_addr_i = addr; ld_byte_en_i = be; ld_zero_extnd_i = z; ld_rd_i = rd;
    #1;
    chk("accept_ready", 64'(ld_ready_o), 64'd1);
    chk("accept_stall", 64'(stall_o), 64'd1);
    step();
    ld_valid_i = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      #1;
      chk("req_hold", 64'(dmem_req_o), 64'd1);
      chk("req_addr_hold", dmem_addr_o, row);
      chk("req_stall", 64'(stall_o), 64'd1);
      step();
    end
    dmem_gnt_i = 1'b1;
    #1;
    chk("req", 64'(dmem_req_o), 64'd1);
    chk("req_addr", dmem_addr_o, row);
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    #1;
    chk("wait_no_req", 64'(dmem_req_o), 64'd0);
    chk("wait_stall", 64'(stall_o), 64'd1);
    step();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("wb_valid", 64'(wb_valid_o), 64'd1);
    chk("wb_rd", 64'(wb_rd_o), 64'(rd));
    chk("wb_raw", data_mem_rd_o, rdata);
    chk("wb_idx", 64'(data_mem_row_idx_o), 64'(addr[2:0]));
    chk("wb_be", 64'(data_byte_en_o), 64'(be));
    chk("wb_zext", 64'(data_zero_extnd_o), 64'(z));
    chk("wb_lane", wb_lane(data_mem_rd_o, data_mem_row_idx_o, data_byte_en_o, data_zero_extnd_o),
        exp_lane);
    chk("resp_stall", 64'(stall_o), 64'd0);
    step();
    #1;
    chk("wb_one_cycle", 64'(wb_valid_o), 64'd0);
    chk("ready_after", 64'(ld_ready_o), 64'd1);
    chk("raw_stable", data_mem_rd_o, rdata);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  be;
    logic        exp_stall;
  } align_vec_t;

  align_vec_t av[6];

  initial begin
    reset = 1'b1; ld_valid_i = 1'b0; ld_addr_i = '0; ld_byte_en_i = '0; ld_zero_extnd_i = 1'b0;
    ld_rd_i = '0; flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(ld_ready_o), 64'd1);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    chk("rst_wb", 64'(wb_valid_o), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_raw", data_mem_rd_o, 64'd0);
    chk("rst_idx", 64'(data_mem_row_idx_o), 64'd0);
    flush_i = 1'b1;
    #1;
    chk("flush_not_ready", 64'(ld_ready_o), 64'd0);
    flush_i = 1'b0;

    // Aligned loads, including byte lane 7 and sign/zero extension cases
    do_load(64'h1000, 2'b11, 1'b0, 5'd5, 0, 64'hFBD2_67A6_10FF_4483, 64'hFBD2_67A6_10FF_4483);
    do_load(64'h2005, 2'b00, 1'b1, 5'd7, 4, 64'h0011_2233_4455_6677, 64'h22);
    do_load(64'h4007, 2'b00, 1'b0, 5'd9, 1, 64'h2811_2233_4455_6677, 64'h28);
    do_load(64'h5006, 2'b01, 1'b0, 5'd3, 0, 64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);
    do_load(64'h6004, 2'b10, 1'b1, 5'd31, 2, 64'h8765_4321_0000_0000, 64'h8765_4321);

    // Alignment boundaries seen on the combinational stall (no clock edge taken)
    av[0] = '{64'h3001, 2'b01, 1'b0};
    av[1] = '{64'h3002, 2'b01, 1'b1};
    av[2] = '{64'h3006, 2'b10, 1'b0};
    av[3] = '{64'h3004, 2'b10, 1'b1};
    av[4] = '{64'h3004, 2'b11, 1'b0};
    av[5] = '{64'h3007, 2'b00, 1'b1};
    for (int i = 0; i < 6; i++) begin
      ld_valid_i = 1'b1; ld_addr_i = av[i].addr; ld_byte_en_i = av[i].be;
      #1;
      chk($sformatf("align_stall_%0d", i), 64'(stall_o), 64'(av[i].exp_stall));
    end
    ld_valid_i = 1'b0;

    // Misaligned LW
    step();
    ld_valid_i = 1'b1; ld_addr_i = 64'h3002; ld_byte_en_i = 2'b10;
    #1;
    chk("mis_stall", 64'(stall_o), 64'd0);
    step();
    ld_valid_i = 1'b0;
    #1;
    chk("mis_pulse", 64'(misalign_o), 64'd1);
    chk("mis_addr", misalign_addr_o, 64'h3002);
    chk("mis_no_req", 64'(dmem_req_o), 64'd0);
    chk("mis_not_ready", 64'(ld_ready_o), 64'd0);
    step();
    chk("mis_one_cycle", 64'(misalign_o), 64'd0);
    chk("mis_ready", 64'(ld_ready_o), 64'd1);
    chk("mis_no_req2", 64'(dmem_req_o), 64'd0);

    // Flush in WAIT, rvalid two cycles later
    ld_valid_i = 1'b1; ld_addr_i = 64'h7000; ld_byte_en_i = 2'b11;
    step();
    ld_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fw_stall", 64'(stall_o), 64'd1);
    step();
    #1;
    chk("drain_stall", 64'(stall_o), 64'd1);
    chk("drain_not_ready", 64'(ld_ready_o), 64'd0);
    step();
    flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("drain_hold", 64'(ld_ready_o), 64'd0);
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("drain_no_wb", 64'(wb_valid_o), 64'd0);
    chk("drain_ready", 64'(ld_ready_o), 64'd1);
    chk("drain_discard", data_mem_rd_o, 64'h8765_4321_0000_0000);

    // Flush in REQ before gnt, then a normal load
    ld_valid_i = 1'b1; ld_addr_i = 64'h8000; ld_byte_en_i = 2'b11;
    step();
    ld_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("freq_req", 64'(dmem_req_o), 64'd1);
    step();
    flush_i = 1'b0;
    #1;
    chk("freq_drop", 64'(dmem_req_o), 64'd0);
    chk("freq_no_wb", 64'(wb_valid_o), 64'd0);
    chk("freq_ready", 64'(ld_ready_o), 64'd1);
    do_load(64'h8008, 2'b11, 1'b0, 5'd12, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Reset in WAIT, stray rvalid afterwards
    ld_valid_i = 1'b1; ld_addr_i = 64'h9003; ld_byte_en_i = 2'b00; ld_rd_i = 5'd17;
    step();
    ld_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mrst_ready", 64'(ld_ready_o), 64'd1);
    chk("mrst_stall", 64'(stall_o), 64'd0);
    chk("mrst_addr", dmem_addr_o, 64'd0);
    chk("mrst_raw", data_mem_rd_o, 64'd0);
    chk("mrst_rd", 64'(wb_rd_o), 64'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h5555_AAAA_5555_AAAA;
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("stray_no_wb", 64'(wb_valid_o), 64'd0);
    chk("stray_raw", data_mem_rd_o, 64'd0);
    chk("stray_ready", 64'(ld_ready_o), 64'd1);
    chk("stray_no_req", 64'(dmem_req_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
